// File: rtl/truth_table_checker.sv
// truth_table_checker
// Exhaustive stimulus engine for an N-input, 1-output combinational DUT.
// Every input vector 0..2**N-1 is driven on dut_in for SETTLE cycles, then
// dut_y is compared with TRUTH[vector]. Mismatches are counted (saturating
// at 2**N) and the lowest failing vector is captured.
//
// Optional feature: define TTC_STOP_ON_FAIL_EN to end the sweep at the
// first mismatch instead of completing all vectors.
//
// Handshake: start is a level, only looked at in IDLE and DONE; while busy
// is high start is ignored. done/pass/err_count/fail_valid/first_fail are
// stable from the first DONE cycle until the next start or reset.
module truth_table_checker #(
  parameter int              N      = 3,
  parameter logic [2**N-1:0] TRUTH  = 8'h35,
  parameter int              SETTLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] dut_in,
  input  logic         dut_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail,
  output logic [1:0]   state_dbg
);

  // Settle counter only has to reach SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N-1:0]  LAST_VEC    = {N{1'b1}};
  localparam logic [N:0]    ERR_MAX     = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_vec;
  logic [SW-1:0] r_settle_cnt;
  logic [N:0]    r_err_count;
  logic          r_fail_valid;
  logic [N-1:0]  r_first_fail;

  logic w_exp_bit;
  logic w_mismatch;
  logic w_last_vec;
  logic w_settle_done;
  logic w_start_sweep;

  assign w_exp_bit     = TRUTH[r_vec];
  // Case-inequality so an X/Z on dut_y is a mismatch in simulation; it
  // reduces to a plain compare in hardware.
  assign w_mismatch    = (dut_y !== w_exp_bit);
  assign w_last_vec    = (r_vec == LAST_VEC);
  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
  assign w_start_sweep = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (w_settle_done) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
`ifdef TTC_STOP_ON_FAIL_EN
        if (w_mismatch || w_last_vec) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_APPLY;
        end
`else
        if (w_last_vec) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_APPLY;
        end
`endif
      end
      S_DONE: begin
        if (start) w_state_nxt = S_APPLY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector, settle counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec        <= '0;
      r_settle_cnt <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_sweep) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
          end
        end
        S_APPLY: begin
          r_settle_cnt <= r_settle_cnt + SW'(1);
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != ERR_MAX) r_err_count <= r_err_count + (N+1)'(1);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_vec;
            end
          end
          if (w_state_nxt == S_APPLY) begin
            r_vec        <= r_vec + N'(1);
            r_settle_cnt <= '0;
          end
        end
        default: begin
          r_vec <= r_vec;
        end
      endcase
    end
  end

  // Vector register doubles as the registered stimulus; it holds the last
  // applied vector in DONE.
  assign dut_in     = r_vec;
  assign busy       = (r_state == S_APPLY) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_err_count == '0);
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: N=3/TRUTH=8'h35/SETTLE=2 instance driven by
// a faulty-DUT model (dut_y = TRUTH ^ fault_mask), plus an N=4 AND4 instance.
module tb_truth_table_checker;

  localparam int          N       = 3;
  localparam int          NV      = 8;
  localparam int          SETTLE  = 2;
  localparam int          VEC_CYC = SETTLE + 1;
  localparam logic [7:0]  TRUTH   = 8'h35;
  localparam int          LIMIT   = 200;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [N-1:0] dut_in;
  logic         dut_y;
  logic         busy, done, pass, fail_valid;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;
  logic [1:0]   state_dbg;
  logic [7:0]   fault_mask;

  logic         start4;
  logic [3:0]   dut_in4;
  logic         dut_y4;
  logic         busy4, done4, pass4, fail_valid4;
  logic [4:0]   err_count4;
  logic [3:0]   first_fail4;
  logic [1:0]   state_dbg4;

  // Combinational DUTs under test.
  assign dut_y  = TRUTH[dut_in] ^ fault_mask[dut_in];
  assign dut_y4 = &dut_in4;

  truth_table_checker #(.N(3), .TRUTH(8'h35), .SETTLE(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail(first_fail), .state_dbg(state_dbg)
  );

  truth_table_checker #(.N(4), .TRUTH(16'h8000), .SETTLE(1)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .dut_in(dut_in4), .dut_y(dut_y4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
    .fail_valid(fail_valid4), .first_fail(first_fail4), .state_dbg(state_dbg4)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] mask;
    int         exp_err;
    int         exp_ff;
    bit         exp_fv;
    bit         exp_pass;
    int         exp_cyc;
    int         exp_last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Reference model: walk the vector list and collect the sweep outcome.
  function automatic vec_t model(input logic [7:0] mask);
    vec_t r;
    r.name     = "rand";
    r.mask     = mask;
    r.exp_err  = 0;
    r.exp_ff   = 0;
    r.exp_fv   = 0;
    r.exp_cyc  = NV * VEC_CYC;
    r.exp_last = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (mask[v]) begin
        if (!r.exp_fv) begin
          r.exp_fv = 1;
          r.exp_ff = v;
`ifdef TTC_STOP_ON_FAIL_EN
          r.exp_cyc  = (v + 1) * VEC_CYC;
          r.exp_last = v;
`endif
        end
        r.exp_err++;
      end
    end
`ifdef TTC_STOP_ON_FAIL_EN
    r.exp_err = r.exp_fv ? 1 : 0;
`endif
    r.exp_pass = (r.exp_err == 0);
    return r;
  endfunction

  // Driver: start a sweep on the next edge, follow it to done.
  task automatic run_sweep(input bit hold, output int cyc);
    bit seq_bad;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    seq_bad = 1'b0;
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      if (dut_in !== 3'(cyc / VEC_CYC)) seq_bad = 1'b1;
      if (busy !== 1'b1) seq_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("sweep_seq", 32'(seq_bad), 32'd0);
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_result(input vec_t e, input int cyc);
    check({e.name, "_cycles"},     32'(cyc),        32'(e.exp_cyc));
    check({e.name, "_err_count"},  32'(err_count),  32'(e.exp_err));
    check({e.name, "_first_fail"}, 32'(first_fail), 32'(e.exp_ff));
    check({e.name, "_fail_valid"}, 32'(fail_valid), 32'(e.exp_fv));
    check({e.name, "_pass"},       32'(pass),       32'(e.exp_pass));
    check({e.name, "_dut_in"},     32'(dut_in),     32'(e.exp_last));
    check({e.name, "_busy"},       32'(busy),       32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"},      32'(state_dbg),  32'd0);
    check({tag, "_dut_in"},     32'(dut_in),     32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_pass"},       32'(pass),       32'd0);
    check({tag, "_err_count"},  32'(err_count),  32'd0);
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
    check({tag, "_first_fail"}, 32'(first_fail), 32'd0);
  endtask

  vec_t tbl[4];
  vec_t e;
  int   cyc;
  int   wait_cyc;
  logic [4:0] held_err;

  initial begin
    // Directed table: {fault mask, expected outcome}.
    tbl[0] = '{"correct", 8'h00, 0, 0, 1'b0, 1'b1, 24, 7};
`ifdef TTC_STOP_ON_FAIL_EN
    tbl[1] = '{"stuck0",  8'h35, 1, 0, 1'b1, 1'b0, 3,  0};
    tbl[2] = '{"wrong6",  8'h40, 1, 6, 1'b1, 1'b0, 21, 6};
    tbl[3] = '{"allbad",  8'hFF, 1, 0, 1'b1, 1'b0, 3,  0};
`else
    tbl[1] = '{"stuck0",  8'h35, 4, 0, 1'b1, 1'b0, 24, 7};
    tbl[2] = '{"wrong6",  8'h40, 1, 6, 1'b1, 1'b0, 24, 7};
    tbl[3] = '{"allbad",  8'hFF, 8, 0, 1'b1, 1'b0, 24, 7};
`endif

    reset      = 1'b1;
    start      = 1'b0;
    start4     = 1'b0;
    fault_mask = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(state_dbg), 32'd0);

    // Table-driven sweeps, back to back (restart from DONE).
    for (int i = 0; i < 4; i++) begin
      fault_mask = tbl[i].mask;
      run_sweep(1'b0, cyc);
      check_result(tbl[i], cyc);
    end

    // Results hold stable in DONE.
    held_err = err_count;
    repeat (3) @(negedge clk);
    check("done_stable", 32'(done), 32'd1);
    check("done_err_stable", 32'(err_count), 32'(tbl[3].exp_err));
    check("done_err_unchanged", 32'(err_count), 32'(held_err));

    // Randomized fault masks against the model.
    for (int i = 0; i < 8; i++) begin
      fault_mask = 8'($urandom_range(0, 255));
      e = model(fault_mask);
      run_sweep(1'b0, cyc);
      check_result(e, cyc);
    end

    // start held high: no restart while busy, restart right after DONE.
    fault_mask = 8'h35;
    e = model(fault_mask);
    e.name = "hold";
    run_sweep(1'b1, cyc);
    check_result(e, cyc);
    @(negedge clk);
    check("hold_restart_busy", 32'(busy),      32'd1);
    check("hold_restart_done", 32'(done),      32'd0);
    check("hold_restart_err",  32'(err_count), 32'd0);
    check("hold_restart_vec",  32'(dut_in),    32'd0);
    start = 1'b0;

    // Reset mid-sweep while dut_in == 4.
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    fault_mask = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (dut_in !== 3'd4 && wait_cyc < LIMIT) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reached_vec4", 32'(dut_in), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    reset = 1'b0;
    e = model(8'h00);
    e.name = "after_rst";
    run_sweep(1'b0, cyc);
    check_result(e, cyc);

    // N=4 AND4 instance, SETTLE=1.
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("and4_cycles",     32'(cyc),         32'd32);
    check("and4_pass",       32'(pass4),       32'd1);
    check("and4_err_count",  32'(err_count4),  32'd0);
    check("and4_fail_valid", 32'(fail_valid4), 32'd0);
    check("and4_dut_in",     32'(dut_in4),     32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
